// File: rtl/csr_pkg.sv
// Shared CSR definitions: addresses, op encodings, interrupt codes and WARL masks.
// CSR_UNIT_VECTORED_EN keeps mtvec[0] writable so vectored interrupt dispatch can be selected.
package csr_pkg;

    typedef enum logic [1:0] {
        CSR_OP_NONE = 2'b00,
        CSR_OP_RW   = 2'b01,
        CSR_OP_RS   = 2'b10,
        CSR_OP_RC   = 2'b11
    } csr_op_e;

    localparam logic [11:0] CSR_MSTATUS       = 12'h300;
    localparam logic [11:0] CSR_MISA          = 12'h301;
    localparam logic [11:0] CSR_MIE           = 12'h304;
    localparam logic [11:0] CSR_MTVEC         = 12'h305;
    localparam logic [11:0] CSR_MCOUNTINHIBIT = 12'h320;
    localparam logic [11:0] CSR_MSCRATCH      = 12'h340;
    localparam logic [11:0] CSR_MEPC          = 12'h341;
    localparam logic [11:0] CSR_MCAUSE        = 12'h342;
    localparam logic [11:0] CSR_MTVAL         = 12'h343;
    localparam logic [11:0] CSR_MIP           = 12'h344;
    localparam logic [11:0] CSR_MCYCLE        = 12'hB00;
    localparam logic [11:0] CSR_MINSTRET      = 12'hB02;
    localparam logic [11:0] CSR_MHPMCOUNTER3  = 12'hB03;
    localparam logic [11:0] CSR_MCYCLEH       = 12'hB80;
    localparam logic [11:0] CSR_CYCLE         = 12'hC00;
    localparam logic [11:0] CSR_INSTRET       = 12'hC02;
    localparam logic [11:0] CSR_HPMCOUNTER3   = 12'hC03;
    localparam logic [11:0] CSR_CYCLEH        = 12'hC80;

    localparam logic [3:0] IRQ_CODE_SW    = 4'd3;
    localparam logic [3:0] IRQ_CODE_TIMER = 4'd7;
    localparam logic [3:0] IRQ_CODE_EXT   = 4'd11;

    localparam logic [31:0] MSTATUS_MPP = 32'h0000_1800;
    localparam logic [31:0] MISA_VALUE  = 32'h4000_0100;
    localparam logic [31:0] MIE_WMASK   = 32'h0000_0888;
`ifdef CSR_UNIT_VECTORED_EN
    localparam logic [31:0] MTVEC_WMASK = 32'hFFFF_FFFD;
`else
    localparam logic [31:0] MTVEC_WMASK = 32'hFFFF_FFFC;
`endif

    function automatic logic [31:0] csr_apply_op(input csr_op_e op, input logic [31:0] old_val,
                                                 input logic [31:0] wdata);
        logic [31:0] res;
        case (op)
            CSR_OP_RW: res = wdata;
            CSR_OP_RS: res = old_val | wdata;
            CSR_OP_RC: res = old_val & ~wdata;
            default:   res = old_val;
        endcase
        return res;
    endfunction

    // Counter k sits at address offset 0 (cycle), 2 (instret), then 3.. for hpm counters.
    function automatic logic [11:0] cnt_offset(input int k);
        return (k == 0) ? 12'd0 : 12'(k + 1);
    endfunction

    function automatic logic [31:0] cinh_wmask(input int num_hpm);
        logic [31:0] m;
        m = 32'h0000_0005;
        for (int j = 0; j < num_hpm; j++) m[3 + j] = 1'b1;
        return m;
    endfunction

endpackage

// File: rtl/csr_unit_if.sv
// CSR access port between the instruction pipeline (master) and the CSR file (slave).
interface csr_unit_if;
    import csr_pkg::*;

    logic [11:0] csr_addr;
    csr_op_e     csr_op;
    logic [31:0] csr_wdata;
    logic [31:0] csr_rdata;
    logic        csr_illegal;

    modport master (
        output csr_addr, csr_op, csr_wdata,
        input  csr_rdata, csr_illegal
    );

    modport slave (
        input  csr_addr, csr_op, csr_wdata,
        output csr_rdata, csr_illegal
    );
endinterface

// File: rtl/csr_counter.sv
// One performance counter of CNT_W bits with independent 32-bit lo/hi software writes.
// A software write to either half wins over the increment in the same cycle.
module csr_counter #(
    parameter int CNT_W = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    input  logic             inhibit,
    input  logic             wr_lo,
    input  logic             wr_hi,
    input  logic [31:0]      wdata,
    output logic [CNT_W-1:0] value
);
    localparam int HI_W = CNT_W - 32;

    logic [CNT_W-1:0] cnt_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_reg <= '0;
        end else if (wr_lo) begin
            cnt_reg[31:0] <= wdata;
        end else if (wr_hi) begin
            cnt_reg[CNT_W-1:32] <= wdata[HI_W-1:0];
        end else if (inc && !inhibit) begin
            cnt_reg <= cnt_reg + CNT_W'(1);
        end
    end

    assign value = cnt_reg;
endmodule

// File: rtl/csr_unit.sv
// Machine-mode CSR file: trap entry/return, interrupt arbitration and performance counters.
// Define CSR_UNIT_VECTORED_EN to allow vectored mtvec dispatch of interrupts.
module csr_unit
    import csr_pkg::*;
#(
    parameter int NUM_HPM = 4,
    parameter int CNT_W   = 64
) (
    input  logic                                    clk,
    input  logic                                    rst_n,
    csr_unit_if.slave                               csr,
    input  logic                                    trap_valid,
    input  logic [31:0]                             trap_cause,
    input  logic [31:0]                             trap_pc,
    input  logic [31:0]                             trap_tval,
    input  logic                                    mret,
    input  logic                                    instret,
    input  logic [((NUM_HPM > 0) ? NUM_HPM : 1)-1:0] hpm_event,
    input  logic                                    irq_sw,
    input  logic                                    irq_timer,
    input  logic                                    irq_ext,
    output logic                                    irq_req,
    output logic [31:0]                             irq_cause,
    output logic [31:0]                             trap_vector,
    output logic [31:0]                             mepc_o
);
    localparam int          NUM_CNT    = 2 + NUM_HPM;
    localparam logic [31:0] CINH_WMASK = cinh_wmask(NUM_HPM);

    logic        mstatus_mie_reg;
    logic        mstatus_mpie_reg;
    logic [31:0] mie_reg;
    logic [31:0] mtvec_reg;
    logic [31:0] mscratch_reg;
    logic [31:0] mepc_reg;
    logic [31:0] mcause_reg;
    logic [31:0] mtval_reg;
    logic [31:0] mip_reg;
    logic [31:0] mcountinhibit_reg;

    logic [CNT_W-1:0]   cnt_val [NUM_CNT];
    logic [NUM_CNT-1:0] cnt_inc;
    logic [NUM_CNT-1:0] cnt_inh;
    logic [NUM_CNT-1:0] cnt_wr_lo;
    logic [NUM_CNT-1:0] cnt_wr_hi;

    logic [31:0] mstatus_val;
    logic [31:0] old_val;
    logic [31:0] new_val;
    logic        addr_known;
    logic        addr_ro;
    logic        wr_req;
    logic        csr_we;
    logic        pend_sw;
    logic        pend_timer;
    logic        pend_ext;
    logic [3:0]  irq_code;
    logic [31:0] vec_base;

    assign mstatus_val = MSTATUS_MPP | {24'b0, mstatus_mpie_reg, 3'b0, mstatus_mie_reg, 3'b0};

    // Read decode; counter addresses depend on NUM_HPM so they are matched in a loop.
    always_comb begin
        old_val    = '0;
        addr_known = 1'b1;
        addr_ro    = 1'b0;
        case (csr.csr_addr)
            CSR_MSTATUS:       old_val = mstatus_val;
            CSR_MISA:          old_val = MISA_VALUE;
            CSR_MIE:           old_val = mie_reg;
            CSR_MTVEC:         old_val = mtvec_reg;
            CSR_MCOUNTINHIBIT: old_val = mcountinhibit_reg;
            CSR_MSCRATCH:      old_val = mscratch_reg;
            CSR_MEPC:          old_val = mepc_reg;
            CSR_MCAUSE:        old_val = mcause_reg;
            CSR_MTVAL:         old_val = mtval_reg;
            CSR_MIP:           old_val = mip_reg;
            default: begin
                addr_known = 1'b0;
                for (int k = 0; k < NUM_CNT; k++) begin
                    if (csr.csr_addr == CSR_MCYCLE + cnt_offset(k)) begin
                        old_val    = cnt_val[k][31:0];
                        addr_known = 1'b1;
                    end else if (csr.csr_addr == CSR_MCYCLEH + cnt_offset(k)) begin
                        old_val    = 32'(cnt_val[k][CNT_W-1:32]);
                        addr_known = 1'b1;
                    end else if (csr.csr_addr == CSR_CYCLE + cnt_offset(k)) begin
                        old_val    = cnt_val[k][31:0];
                        addr_known = 1'b1;
                        addr_ro    = 1'b1;
                    end else if (csr.csr_addr == CSR_CYCLEH + cnt_offset(k)) begin
                        old_val    = 32'(cnt_val[k][CNT_W-1:32]);
                        addr_known = 1'b1;
                        addr_ro    = 1'b1;
                    end
                end
            end
        endcase
    end

    // Set/clear with a zero operand is a pure read, so it may target read-only CSRs.
    assign wr_req = (csr.csr_op == CSR_OP_RW) ||
                    (((csr.csr_op == CSR_OP_RS) || (csr.csr_op == CSR_OP_RC)) && (csr.csr_wdata != '0));
    assign csr.csr_illegal = (csr.csr_op != CSR_OP_NONE) && (!addr_known || (addr_ro && wr_req));
    assign csr_we    = wr_req && addr_known && !addr_ro && !trap_valid && !mret;
    assign new_val   = csr_apply_op(csr.csr_op, old_val, csr.csr_wdata);
    assign csr.csr_rdata = old_val;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_CNT; gi++) begin : g_cnt
            localparam logic [11:0] OFF = cnt_offset(gi);

            assign cnt_wr_lo[gi] = csr_we && (csr.csr_addr == CSR_MCYCLE + OFF);
            assign cnt_wr_hi[gi] = csr_we && (csr.csr_addr == CSR_MCYCLEH + OFF);
            assign cnt_inh[gi]   = mcountinhibit_reg[OFF[4:0]];

            if (gi == 0) begin : g_cycle
                assign cnt_inc[gi] = 1'b1;
            end else if (gi == 1) begin : g_instret
                assign cnt_inc[gi] = instret;
            end else begin : g_hpm
                assign cnt_inc[gi] = hpm_event[gi-2];
            end

            csr_counter #(
                .CNT_W(CNT_W)
            ) u_counter (
                .clk    (clk),
                .rst_n  (rst_n),
                .inc    (cnt_inc[gi]),
                .inhibit(cnt_inh[gi]),
                .wr_lo  (cnt_wr_lo[gi]),
                .wr_hi  (cnt_wr_hi[gi]),
                .wdata  (new_val),
                .value  (cnt_val[gi])
            );
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mstatus_mie_reg   <= 1'b0;
            mstatus_mpie_reg  <= 1'b0;
            mie_reg           <= '0;
            mtvec_reg         <= '0;
            mscratch_reg      <= '0;
            mepc_reg          <= '0;
            mcause_reg        <= '0;
            mtval_reg         <= '0;
            mip_reg           <= '0;
            mcountinhibit_reg <= '0;
        end else begin
            // Pending bits are sampled copies of the level sources; software writes never reach them.
            mip_reg <= {20'b0, irq_ext, 3'b0, irq_timer, 3'b0, irq_sw, 3'b0};
            if (trap_valid) begin
                mepc_reg         <= trap_pc & ~32'h3;
                mcause_reg       <= trap_cause;
                mtval_reg        <= trap_tval;
                mstatus_mpie_reg <= mstatus_mie_reg;
                mstatus_mie_reg  <= 1'b0;
            end else if (mret) begin
                mstatus_mie_reg  <= mstatus_mpie_reg;
                mstatus_mpie_reg <= 1'b1;
            end else if (csr_we) begin
                case (csr.csr_addr)
                    CSR_MSTATUS: begin
                        mstatus_mie_reg  <= new_val[3];
                        mstatus_mpie_reg <= new_val[7];
                    end
                    CSR_MIE:           mie_reg           <= new_val & MIE_WMASK;
                    CSR_MTVEC:         mtvec_reg         <= new_val & MTVEC_WMASK;
                    CSR_MCOUNTINHIBIT: mcountinhibit_reg <= new_val & CINH_WMASK;
                    CSR_MSCRATCH:      mscratch_reg      <= new_val;
                    CSR_MEPC:          mepc_reg          <= new_val;
                    CSR_MCAUSE:        mcause_reg        <= new_val;
                    CSR_MTVAL:         mtval_reg         <= new_val;
                    default: ;
                endcase
            end
        end
    end

    assign pend_sw    = mie_reg[3]  & mip_reg[3];
    assign pend_timer = mie_reg[7]  & mip_reg[7];
    assign pend_ext   = mie_reg[11] & mip_reg[11];

    always_comb begin
        irq_code = 4'd0;
        if (pend_ext)        irq_code = IRQ_CODE_EXT;
        else if (pend_sw)    irq_code = IRQ_CODE_SW;
        else if (pend_timer) irq_code = IRQ_CODE_TIMER;
    end

    assign irq_req   = mstatus_mie_reg & (pend_sw | pend_timer | pend_ext);
    assign irq_cause = {1'b1, 27'b0, irq_code};
    assign vec_base  = {mtvec_reg[31:2], 2'b00};
    assign mepc_o    = mepc_reg;

`ifdef CSR_UNIT_VECTORED_EN
    assign trap_vector = ((mtvec_reg[1:0] == 2'b01) && irq_req) ?
                         vec_base + {26'b0, irq_code, 2'b00} : vec_base;
`else
    assign trap_vector = vec_base;
`endif

endmodule

// File: doc/csr_unit.md
CSR_UNIT -- requirements
Module: csr_unit

Interface
REQ-001 SHALL have parameter NUM_HPM, default 4, number of mhpmcounter3.. counters (0..8).
REQ-002 SHALL have parameter CNT_W, default 64, counter width (33..64); reads above bit CNT_W-1 return 0.
REQ-003 SHALL have clk  in  1  single clock; all state updates on rising edge.
REQ-004 SHALL have rst_n  in  1  asynchronous, active-low reset.
REQ-005 SHALL have csr_addr  in  12  CSR address.
REQ-006 SHALL have csr_op  in  2  00 none, 01 RW, 10 RS (set), 11 RC (clear).
REQ-007 SHALL have csr_wdata  in  32  operand (register or zero-extended immediate).
REQ-008 SHALL have csr_rdata  out  32  old CSR value, combinational.
REQ-009 SHALL have csr_illegal  out  1  unknown address, or write to a read-only CSR.
REQ-010 SHALL have trap_valid, trap_cause[31:0], trap_pc[31:0], trap_tval[31:0]  in  trap entry request with its data.
REQ-011 SHALL have mret  in  1  return from trap.
REQ-012 SHALL have instret  in  1  one instruction retired this cycle.
REQ-013 SHALL have hpm_event  in  NUM_HPM  per-counter increment strobes.
REQ-014 SHALL have irq_sw, irq_timer, irq_ext  in  1 each  level interrupt sources.
REQ-015 SHALL have irq_req  out  1, irq_cause  out  32  arbitrated interrupt request.
REQ-016 SHALL have trap_vector  out  32, mepc_o  out  32  redirect targets.

Function
REQ-017 SHALL implement mstatus, misa, mie, mtvec, mscratch, mepc, mcause, mtval, mip, mcountinhibit, mcycle(h), minstret(h), mhpmcounterN(h), and read-only cycle(h)/instret(h)/hpmcounterN(h) shadows.
REQ-018 SHALL write new = RW: wdata; RS: old|wdata; RC: old&~wdata; RS/RC with wdata==0 SHALL NOT write and SHALL NOT flag a read-only CSR.
REQ-019 SHALL commit the write on the next edge; csr_rdata SHALL return the pre-write value in the same cycle.
REQ-020 SHALL WARL-mask fields: mstatus writable only at bits 3 (MIE) and 7 (MPIE), MPP SHALL read 2'b11; mie/mip writable only at bits 3, 7, 11; mip bits 3/7/11 SHALL track irq_sw/irq_timer/irq_ext and ignore writes; misa SHALL read 32'h40000100.
REQ-021 SHALL drive irq_req = mstatus.MIE & |(mie&mip), priority ext(11) > sw(3) > timer(7); irq_cause = {1'b1, 27'b0, code}.
REQ-022 SHALL, on trap_valid: mepc<=trap_pc&~3, mcause<=trap_cause, mtval<=trap_tval, MPIE<=MIE, MIE<=0.
REQ-023 SHALL, on mret without trap_valid: MIE<=MPIE, MPIE<=1.
REQ-024 SHALL apply precedence trap_valid > mret > CSR write, dropping the lower-priority actions in that cycle.
REQ-025 SHALL increment mcycle each cycle, minstret on instret, and counter N on hpm_event[N], each gated by its mcountinhibit bit; counters SHALL wrap modulo 2^CNT_W.
REQ-026 SHALL, on a software write to a counter half in the same cycle as an increment, take the written half and leave the other half unchanged, with no increment.
REQ-027 SHALL drive trap_vector = {mtvec[31:2],2'b00}; mepc_o = mepc.

Reset
REQ-028 SHALL, while rst_n is low: mstatus=32'h1800, and mie, mtvec, mscratch, mepc, mcause, mtval, mip, mcountinhibit and all counters = 0.
REQ-029 SHALL hold irq_req=0 during reset; csr_rdata SHALL reflect reset values.

Configuration
REQ-030 SHALL compile vectored mtvec when CSR_UNIT_VECTORED_EN is defined: with mtvec[1:0]==01 and irq_req, trap_vector = base + 4*code; otherwise base.
REQ-031 SHALL, when CSR_UNIT_VECTORED_EN is undefined, read mtvec[1:0] as 00, ignore writes to those bits, and always drive trap_vector = base.

Structure
REQ-032 SHALL place CSR address constants, csr_op encodings, cause codes and WARL masks in shared package csr_pkg.
REQ-033 SHALL implement counters via sub-module csr_counter (width CNT_W, inc, inhibit, lo/hi write), instantiated 2+NUM_HPM times.

Verification
REQ-034 SHALL test: RW mscratch 0xA5A5A5A5, then RS 0x0F, then RC 0xA0 -> rdata returns 0xA5A5A5A5 then 0xA5A5A5AF; final value 0xA5A5A50F.
REQ-035 SHALL test: mstatus.MIE=1, mie=0x888, irq_timer=1 and irq_ext=1 -> irq_cause=0x8000000B; drop irq_ext -> 0x80000007.
REQ-036 SHALL test: trap_valid with pc 0x102, cause 2 while mret and a write to mepc are asserted -> mepc=0x100, mcause=2, MIE=0, write discarded; a following mret restores MIE=1.
REQ-037 SHALL test: mcycle written 0xFFFFFFFF, mcycleh 0 -> next cycle mcycleh=1; instret for 5 cycles with mcountinhibit[2]=1 -> minstret unchanged.
REQ-038 SHALL test: CSRRW to 0xC00 -> csr_illegal=1 and no state change; CSRRS 0xC00 with wdata=0 -> csr_illegal=0.
REQ-039 SHALL test, with CSR_UNIT_VECTORED_EN defined: mtvec=0x1001 and timer interrupt -> trap_vector=0x101C; with the macro undefined -> 0x1000.
